id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline stage of the 16-bit BRISC core, sitting directly upstream of the ALU. It registers the decoded instruction and register-file operands, and forwards results from the MEM and WB stages. It selects immediate versus register for the ALU `a` input and drives `a`, `b` and `alu_control`. It also detects load-use hazards, stalling decode and inserting a bubble, and honours pipeline stall and branch flush.

## Interface
- `DATA_W`, 16, operand/data width
- `REG_AW`, 3, register address width (8 registers; r0 reads as zero)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_rs`, `id_rt`, `id_rd`  in  REG_AW  source/source/destination register numbers
- `id_rs_data`, `id_rt_data`  in  DATA_W  register-file read data
- `id_imm`  in  DATA_W  sign/zero-extended immediate (extension done in decode)
- `id_use_imm`  in  1  `a` operand = immediate instead of rs
- `id_alu_control`  in  3  ALU function select
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  control bits carried forward
- `mem_rd`  in  REG_AW  destination of the instruction in MEM
- `mem_reg_write`  in  1  MEM instruction writes a register
- `mem_result`  in  DATA_W  registered ALU result in MEM
- `wb_rd`, `wb_reg_write`, `wb_data`  in  REG_AW/1/DATA_W  writeback destination, enable and data
- `stall_in`  in  1  freeze the stage (downstream memory wait)
- `flush`  in  1  branch taken; kill the instruction entering the stage
- `alu_a`, `alu_b`  out  DATA_W  ALU operands; the ALU computes `b-a`, `b<<a` and `b>>a`
- `alu_control`  out  3  registered function select
- `ex_valid`  out  1  stage holds a live instruction
- `ex_rd`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  registered control
- `ex_store_data`  out  DATA_W  forwarded rs value, used as store data
- `id_stall`  out  1  decode/fetch must hold this cycle

## Operation
- Registered state: valid, rs, rt, rd, rs_data, rt_data, imm, use_imm, alu_control, reg_write, mem_read, mem_write.
- Forwarding is combinational on the registered source number `s`, producing `fwd(s)`:
  - `s==0` gives 0.
  - Otherwise, if `mem_reg_write && mem_rd==s`, gives `mem_result`.
  - Otherwise, if `wb_reg_write && wb_rd==s`, gives `wb_data`.
  - Otherwise gives the registered data.
  - MEM has priority over WB.
- Operand drive:
  - `alu_a = use_imm ? imm : fwd(rs)`
  - `alu_b = fwd(rt)`
  - `ex_store_data = fwd(rs)`
- Load-use hazard:
  - `id_stall = ex_valid && ex_mem_read && ex_rd!=0 && id_valid && ((id_rs==ex_rd && !id_use_imm) || id_rt==ex_rd)`.
  - `id_stall` is also 1 whenever `stall_in` is 1.
- Update priority at each clock edge:
  1. `flush` clears valid and all write/mem enables, even if `stall_in` is 1.
  2. Else `stall_in` holds all state.
  3. Else a hazard loads a bubble (valid=0, enables=0, other fields don't-care).
  4. Else the stage loads the `id_*` inputs. Valid becomes `id_valid`; enables are gated by `id_valid`.
- The stage has no FSM beyond these states: live instruction, bubble, held. A hazard always produces exactly one bubble; the load then sits in WB, and WB forwarding supplies its data.
- Enables `ex_reg_write`, `ex_mem_read` and `ex_mem_write` are 0 whenever `ex_valid` is 0.

## Timing
- Reset, asynchronous: all registers go to 0.
  - `ex_valid=0`, `alu_control=000`, `ex_rd=0`, all enables 0.
  - `alu_a=alu_b=ex_store_data=0`, because the sources are r0.
  - `id_stall=stall_in`.
- Reset mid-operation discards the held instruction. There is no partial state.
- Latency: the instruction presented at edge N appears on the outputs after edge N. Operands reflect forwarding inputs in the same cycle (combinational path).
- `id_stall` is combinational from the current state and the `id_*` inputs. Decode must hold its inputs while `id_stall=1`.
- Forwarding inputs must be stable before the edge; they are never registered here.

## Test plan
- Reset pulse while stage holds a valid add -> `ex_valid=0`, `alu_a=alu_b=0`, `alu_control=000` immediately; `id_stall=0`.
- ID: rt=r2, `id_rt_data=0x0005`, imm=0x0003, `use_imm=1`, ctrl=001 -> next cycle `alu_a=0x0003`, `alu_b=0x0005`, `alu_control=001`, `ex_valid=1`.
- Stage rt=r3 (data 0x0000); `mem_rd=3`, `mem_reg_write=1`, `mem_result=0x1234`; `wb_rd=3`, `wb_data=0xBEEF` -> `alu_b=0x1234`; drop `mem_reg_write` -> `alu_b=0xBEEF`; drop `wb_reg_write` -> `0x0000`.
- Stage holds load rd=r4; ID presents rs=r4, `use_imm=0` -> `id_stall=1`. Next cycle `ex_valid=0`, `id_stall=0`. Following edge loads the dependent instruction; with `wb_rd=4`, `wb_data=0x00AA`, `alu_a=0x00AA`.
- Same hazard but ID uses immediate and rt!=r4 -> `id_stall=0`, no bubble.
- `flush=1` with `stall_in=1` and valid ID -> next cycle `ex_valid=0`, `ex_reg_write=0`. Source r0 with `mem_rd=0`, `mem_reg_write=1`, `mem_result=0xFFFF` -> operand 0x0000.

Source files
------------

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 16-bit BRISC core: operand forwarding,
// immediate select, load-use hazard detection, stall hold and branch flush.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [2:0]        id_alu_control,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              stall_in,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              id_stall
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        logic [2:0]        alu_control;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } stage_t;

    stage_t            stage_q;
    stage_t            stage_d;
    logic              hazard_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    // MEM beats WB; r0 is hard zero even if some stage claims to write it.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] reg_data,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [DATA_W-1:0] m_res,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we,
        input logic [DATA_W-1:0] w_dat
    );
        logic [DATA_W-1:0] val;
        if (src == {REG_AW{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (m_we && (m_rd == src)) begin
            val = m_res;
        end else if (w_we && (w_rd == src)) begin
            val = w_dat;
        end else begin
            val = reg_data;
        end
        return val;
    endfunction

    // Combinational forwarding and load-use hazard detection.
    always_comb begin
        fwd_rs_s = fwd(stage_q.rs, stage_q.rs_data, mem_rd, mem_reg_write, mem_result,
                       wb_rd, wb_reg_write, wb_data);
        fwd_rt_s = fwd(stage_q.rt, stage_q.rt_data, mem_rd, mem_reg_write, mem_result,
                       wb_rd, wb_reg_write, wb_data);
        hazard_s = stage_q.valid && stage_q.mem_read && (stage_q.rd != {REG_AW{1'b0}}) &&
                   id_valid && (((id_rs == stage_q.rd) && !id_use_imm) || (id_rt == stage_q.rd));
    end

    // Next-state: flush beats stall, stall beats hazard bubble, otherwise load decode.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.valid     = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
        end else if (stall_in) begin
            stage_d = stage_q;
        end else if (hazard_s) begin
            stage_d.valid     = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
        end else begin
            stage_d.valid       = id_valid;
            stage_d.rs          = id_rs;
            stage_d.rt          = id_rt;
            stage_d.rd          = id_rd;
            stage_d.rs_data     = id_rs_data;
            stage_d.rt_data     = id_rt_data;
            stage_d.imm         = id_imm;
            stage_d.use_imm     = id_use_imm;
            stage_d.alu_control = id_alu_control;
            stage_d.reg_write   = id_reg_write && id_valid;
            stage_d.mem_read    = id_mem_read && id_valid;
            stage_d.mem_write   = id_mem_write && id_valid;
        end
    end

    // Stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign alu_a         = stage_q.use_imm ? stage_q.imm : fwd_rs_s;
    assign alu_b         = fwd_rt_s;
    assign ex_store_data = fwd_rs_s;
    assign alu_control   = stage_q.alu_control;
    assign ex_valid      = stage_q.valid;
    assign ex_rd         = stage_q.rd;
    assign ex_reg_write  = stage_q.reg_write;
    assign ex_mem_read   = stage_q.mem_read;
    assign ex_mem_write  = stage_q.mem_write;
    assign id_stall      = hazard_s || stall_in;

endmodule
